// File: rtl/vid_capture_pkg.sv
// vid_capture_pkg: shared state encoding, hires address packing and default capture geometry
package vid_capture_pkg;

    localparam int ADDR_W      = 15;
    localparam int X_W         = 7;
    localparam int Y_W         = 8;
    localparam int H_BYTES_DEF = 80;
    localparam int V_LINES_DEF = 240;
    localparam int H_START_DEF = 48;
    localparam int V_START_DEF = 16;

    typedef enum logic [2:0] {
        WAIT_VS,
        VPORCH,
        HPORCH,
        ACTIVE,
        LINE_END
    } state_t;

    // Same {x, y} layout the display path uses on readout
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/vid_capture_sync_edge.sv
// sync_edge: 2-flop synchroniser for an asynchronous pin with rise/fall pulses on the synchronised copy
module sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sh_q;

    // sh_q[1:0] is the synchroniser, sh_q[2] holds the previous synchronised value for edge detection
    always_ff @(posedge clk) begin
        if (srst) sh_q <= '0;
        else      sh_q <= {sh_q[1:0], d_i};
    end

    assign level_o = sh_q[1];
    assign rise_o  = sh_q[1] & ~sh_q[2];
    assign fall_o  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/vid_capture.sv
// vid_capture: rebuilds the hires byte frame from an external mono raster; VID_CAPTURE_LINE_DECIM_EN keeps only even lines of a line-doubled source
module vid_capture
    import vid_capture_pkg::*;
#(
    parameter int H_BYTES = H_BYTES_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int H_START = H_START_DEF,
    parameter int V_START = V_START_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              pix_en,
    input  logic              vid_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              locked,
    output logic              short_line
);

    localparam int HCW = $clog2(H_START) + 1;
    localparam int VCW = $clog2(V_START) + 1;

    logic vid_lvl, vid_rise, vid_fall;
    logic hs_lvl, hs_rise, hs_fall;
    logic vs_lvl, vs_rise, vs_fall;

    sync_edge u_vid (.clk(clk), .srst(srst), .d_i(vid_in),   .level_o(vid_lvl), .rise_o(vid_rise), .fall_o(vid_fall));
    sync_edge u_hs  (.clk(clk), .srst(srst), .d_i(hsync_in), .level_o(hs_lvl),  .rise_o(hs_rise),  .fall_o(hs_fall));
    sync_edge u_vs  (.clk(clk), .srst(srst), .d_i(vsync_in), .level_o(vs_lvl),  .rise_o(vs_rise),  .fall_o(vs_fall));

    state_t            state_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [HCW-1:0]    hcnt_q;
    logic [VCW-1:0]    vcnt_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              frame_done_q;
    logic              locked_q;
    logic              short_line_q;

    logic [7:0] byte_d;
    logic       line_end_d;
    logic       y_step_d;
    logic       write_ok_d;
    logic       end_frame_d;

    assign byte_d     = {shift_q[6:0], vid_lvl};
    assign line_end_d = hs_fall && (state_q == ACTIVE || state_q == LINE_END);

`ifdef VID_CAPTURE_LINE_DECIM_EN
    logic parity_q;
    // Odd source lines are the duplicate half of a doubled pair: traversed but never stored
    assign y_step_d   = parity_q;
    assign write_ok_d = ~parity_q;
`else
    assign y_step_d   = 1'b1;
    assign write_ok_d = 1'b1;
`endif

    assign end_frame_d = y_step_d && (y_q == Y_W'(V_LINES - 1));

    // Capture FSM: vsync abort beats line end, which beats normal per-state progress
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= WAIT_VS;
            x_q          <= '0;
            y_q          <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            short_line_q <= 1'b0;
`ifdef VID_CAPTURE_LINE_DECIM_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (vs_fall) begin
                if (state_q != WAIT_VS) locked_q <= 1'b0;
                state_q <= VPORCH;
                vcnt_q  <= '0;
                hcnt_q  <= '0;
                x_q     <= '0;
                y_q     <= '0;
                bit_q   <= '0;
`ifdef VID_CAPTURE_LINE_DECIM_EN
                parity_q <= 1'b0;
`endif
            end else if (line_end_d) begin
                if (state_q == ACTIVE) short_line_q <= 1'b1;
                if (y_step_d) y_q <= y_q + 1'b1;
                if (end_frame_d) begin
                    frame_done_q <= 1'b1;
                    locked_q     <= 1'b1;
                    state_q      <= WAIT_VS;
                end else begin
                    hcnt_q  <= '0;
                    state_q <= HPORCH;
                end
`ifdef VID_CAPTURE_LINE_DECIM_EN
                parity_q <= ~parity_q;
`endif
            end else begin
                case (state_q)
                    VPORCH: begin
                        if (hs_fall) begin
                            if (vcnt_q == VCW'(V_START - 1)) begin
                                y_q     <= '0;
                                hcnt_q  <= '0;
                                state_q <= HPORCH;
                            end else begin
                                vcnt_q <= vcnt_q + 1'b1;
                            end
                        end
                    end
                    HPORCH: begin
                        if (pix_en) begin
                            if (hcnt_q == HCW'(H_START - 1)) begin
                                x_q     <= '0;
                                bit_q   <= '0;
                                state_q <= ACTIVE;
                            end else begin
                                hcnt_q <= hcnt_q + 1'b1;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (pix_en) begin
                            shift_q <= byte_d;
                            bit_q   <= bit_q + 1'b1;
                            if (bit_q == 3'd7) begin
                                wr_en_q   <= write_ok_d;
                                wr_data_q <= byte_d;
                                wr_addr_q <= pack_addr(x_q, y_q);
                                x_q       <= x_q + 1'b1;
                                if (x_q == X_W'(H_BYTES - 1)) state_q <= LINE_END;
                            end
                        end
                    end
                    WAIT_VS, LINE_END: ;
                    default: state_q <= WAIT_VS;
                endcase
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;
    assign short_line = short_line_q;

    logic unused_sigs;
    assign unused_sigs = ^{vid_rise, vid_fall, hs_rise, hs_lvl, vs_rise, vs_lvl, shift_q[7]};

endmodule

// File: tb/tb_vid_capture.sv
// tb_vid_capture: directed checks of frame capture, pixel order, short line, early vsync, sync collision and reset
module tb_vid_capture;
    import vid_capture_pkg::*;

    localparam int HB = 4;
    localparam int VL = 6;
    localparam int HS = 5;
    localparam int VS = 3;

    logic clk = 1'b0, srst = 1'b1, pix_en = 1'b0, vid_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic wr_en, frame_done, locked, short_line;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0] wr_data;

    int checks = 0, errors = 0;
    int wr_cnt = 0, fd_cnt = 0, b2b = 0, fid = 0;
    logic prev_wr = 1'b0;
    logic [7:0] mem [0:32767];
    int tag [0:32767];

    always #5 clk = ~clk;

    vid_capture #(.H_BYTES(HB), .V_LINES(VL), .H_START(HS), .V_START(VS)) dut (
        .clk(clk), .srst(srst), .pix_en(pix_en), .vid_in(vid_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .locked(locked), .short_line(short_line)
    );

    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            wr_cnt++;
            mem[wr_addr] = wr_data;
            tag[wr_addr] = fid;
        end
        if (wr_en && prev_wr) b2b++;
        prev_wr = wr_en;
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [7:0] src_byte(input int y, input int x);
        if (y == 0 && x == 0) return 8'h81;
        return ((x + y) % 2 == 0) ? 8'hAA : 8'h55;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic px(input logic v);
        vid_in = v;
        tick(2);
        pix_en = 1'b1;
        tick(1);
        pix_en = 1'b0;
    endtask

    task automatic hs_pulse();
        hsync_in = 1'b1;
        tick(4);
        hsync_in = 1'b0;
        tick(4);
    endtask

    task automatic vs_pulse();
        vsync_in = 1'b1;
        tick(4);
        vsync_in = 1'b0;
        tick(4);
    endtask

    task automatic frame_head();
        vs_pulse();
        repeat (VS) hs_pulse();
    endtask

    task automatic send_line(input int y, input int npix, input bit end_hs);
        logic [7:0] b;
        logic [ADDR_W-1:0] ea;
        for (int i = 0; i < HS; i++) px(1'b0);
        for (int p = 0; p < npix; p++) begin
            b = src_byte(y, p / 8);
            px(b[7 - (p % 8)]);
            if (p % 8 == 7) begin
                ea = {7'(p / 8), 8'(y)};
                chk("byte_wr_en", 32'(wr_en), 32'd1);
                chk("byte_wr_addr", 32'(wr_addr), 32'(ea));
                chk("byte_wr_data", 32'(wr_data), 32'(b));
            end
        end
        if (end_hs) hs_pulse();
    endtask

    initial begin
        int bw, bf, bad, w0;
        logic [7:0] lastb;
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_short_line", 32'(short_line), 32'd0);
        srst = 1'b0;
        tick(2);

        fid = 1; bw = wr_cnt; bf = fd_cnt;
        frame_head();
        for (int y = 0; y < VL; y++) send_line(y, HB * 8, 1'b1);
        tick(4);
        chk("A_writes", 32'(wr_cnt - bw), 32'(HB * VL));
        chk("A_frame_done", 32'(fd_cnt - bf), 32'd1);
        chk("A_locked", 32'(locked), 32'd1);
        chk("A_short_line", 32'(short_line), 32'd0);
        chk("A_addr00", 32'(mem[15'h0000]), 32'h81);
        chk("A_addr10", 32'(mem[15'h0100]), 32'h55);
        bad = 0;
        for (int y = 0; y < VL; y++)
            for (int x = 0; x < HB; x++)
                if (tag[{7'(x), 8'(y)}] != fid || mem[{7'(x), 8'(y)}] !== src_byte(y, x)) bad++;
        chk("A_content", 32'(bad), 32'd0);

        fid = 2; bw = wr_cnt; bf = fd_cnt;
        frame_head();
        for (int y = 0; y < VL; y++) send_line(y, (y == 2) ? 19 : HB * 8, 1'b1);
        tick(4);
        chk("B_short_line", 32'(short_line), 32'd1);
        chk("B_writes", 32'(wr_cnt - bw), 32'(HB * VL - 2));
        chk("B_x1y2_written", 32'(tag[15'h0102] == fid), 32'd1);
        chk("B_x2y2_skipped", 32'(tag[15'h0202] == fid), 32'd0);
        chk("B_x3y2_skipped", 32'(tag[15'h0302] == fid), 32'd0);
        chk("B_frame_done", 32'(fd_cnt - bf), 32'd1);

        fid = 3; bw = wr_cnt; bf = fd_cnt;
        frame_head();
        for (int y = 0; y < 3; y++) send_line(y, HB * 8, 1'b1);
        send_line(3, 13, 1'b0);
        chk("C_locked_before", 32'(locked), 32'd1);
        w0 = wr_cnt;
        vs_pulse();
        chk("C_locked_abort", 32'(locked), 32'd0);
        chk("C_no_partial", 32'(wr_cnt - w0), 32'd0);
        repeat (VS) hs_pulse();
        for (int y = 0; y < VL; y++) send_line(y, HB * 8, 1'b1);
        tick(4);
        chk("C_writes", 32'(wr_cnt - bw), 32'(13 + HB * VL));
        chk("C_locked_after", 32'(locked), 32'd1);
        chk("C_frame_done", 32'(fd_cnt - bf), 32'd1);

        fid = 4; bw = wr_cnt; bf = fd_cnt;
        frame_head();
        send_line(0, HB * 8, 1'b1);
        send_line(1, HB * 8, 1'b1);
        send_line(2, HB * 8, 1'b0);
        hsync_in = 1'b1; vsync_in = 1'b1;
        tick(4);
        hsync_in = 1'b0; vsync_in = 1'b0;
        tick(4);
        chk("D_no_frame_done", 32'(fd_cnt - bf), 32'd0);
        chk("D_locked", 32'(locked), 32'd0);
        chk("D_writes", 32'(wr_cnt - bw), 32'(3 * HB));
        repeat (VS) hs_pulse();
        send_line(0, HB * 8, 1'b1);
        send_line(1, 7, 1'b0);
        w0 = wr_cnt;
        lastb = src_byte(1, 0);
        vid_in = lastb[0];
        tick(2);
        pix_en = 1'b1;
        srst = 1'b1;
        tick(1);
        pix_en = 1'b0;
        chk("R_wr_en", 32'(wr_en), 32'd0);
        chk("R_wr_addr", 32'(wr_addr), 32'd0);
        chk("R_wr_data", 32'(wr_data), 32'd0);
        chk("R_short_line", 32'(short_line), 32'd0);
        chk("R_locked", 32'(locked), 32'd0);
        srst = 1'b0;
        tick(2);
        chk("R_no_write", 32'(wr_cnt - w0), 32'd0);

        fid = 5; bw = wr_cnt; bf = fd_cnt;
        hs_pulse();
        hs_pulse();
        frame_head();
        for (int y = 0; y < VL; y++) send_line(y, HB * 8, 1'b1);
        tick(4);
        chk("E_writes", 32'(wr_cnt - bw), 32'(HB * VL));
        chk("E_frame_done", 32'(fd_cnt - bf), 32'd1);
        chk("E_locked", 32'(locked), 32'd1);
        chk("no_back_to_back", 32'(b2b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
